// File: rtl/lc3_clk_pkg.sv
`default_nettype none
// ============================================================================
// lc3_clk_pkg : shared types and constants for the LC-3 slow-clock controller
// Revision    : 1.0
// ============================================================================
package lc3_clk_pkg;

  localparam int CLK_HZ           = 50000000;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_HALT = 2;
  localparam int NUM_BTNS = 3;

  typedef enum logic [1:0] {
    ST_HALTED    = 2'b00,
    ST_RUNNING   = 2'b01,
    ST_STEP_WAIT = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : synchronises a raw pushbutton, accepts a level change only
//                after DEBOUNCE_CYCLES stable cycles, pulses press on accepted 1
// Revision     : 1.0
// ============================================================================
module btn_debounce
  import lc3_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    // Any cycle where the synchronised level agrees with stable restarts the count
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// cpu_step_ctrl : turns rising edges of the 1 Hz divider output into one-cycle
//                 CPU enables, gated by a RUN/STEP/HALT button state machine
// Revision      : 1.0
// ============================================================================
module cpu_step_ctrl
  import lc3_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_halt,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] unused_level;

  assign btn_raw = {btn_halt, btn_step, btn_run};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_raw[i]),
      .level (unused_level[i]),
      .press (btn_press[i])
    );
  end

  // Slow-clock synchroniser and rising-edge detector
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       p_q, p_d;
  logic [1:0] vld_q, vld_d;
  logic       tick;

  // p is held high until s2 carries a genuine sample, so a slow_in already
  // high when reset is released is not mistaken for a rising edge
  always_comb begin
    s1_d  = slow_in;
    s2_d  = s1_q;
    vld_d = {vld_q[0], 1'b1};
    p_d   = vld_q[1] ? s2_q : 1'b1;
  end

  assign tick = s2_q & ~p_q;

  // Mode FSM
  state_e           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             halt_evt;

  assign halt_evt = btn_press[BTN_HALT] | halt_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      p_q          <= 1'b1;
      vld_q        <= 2'b00;
      state_q      <= ST_HALTED;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      p_q          <= p_d;
      vld_q        <= vld_d;
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: begin
        if (!halt_evt) begin
          if (btn_press[BTN_RUN])       state_d = ST_RUNNING;
          else if (btn_press[BTN_STEP]) state_d = ST_STEP_WAIT;
        end
      end
      ST_RUNNING: begin
        if (halt_evt) state_d = ST_HALTED;
      end
      ST_STEP_WAIT: begin
        if (halt_evt || tick) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    cpu_en_d = 1'b0;
    if (!halt_evt && tick &&
        (state_q == ST_RUNNING || state_q == ST_STEP_WAIT)) begin
      cpu_en_d = 1'b1;
    end
    step_count_d = step_count_q + (cpu_en_d ? CNT_W'(1) : CNT_W'(0));
  end

  assign cpu_en     = cpu_en_q;
  assign state      = state_q;
  assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cpu_step_ctrl : random stimulus against an edge-history reference model
// Revision         : 1.0
// ============================================================================
module tb_cpu_step_ctrl;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int MAXE = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_in = 1'b0;
  logic          btn_run = 1'b0;
  logic          btn_step = 1'b0;
  logic          btn_halt = 1'b0;
  logic          halt_req = 1'b0;
  logic          cpu_en;
  logic [1:0]    state;
  logic [CW-1:0] step_count;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .slow_in   (slow_in),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_halt  (btn_halt),
    .halt_req  (halt_req),
    .cpu_en    (cpu_en),
    .state     (state),
    .step_count(step_count)
  );

  // Per-edge history of sampled inputs; index = edge number
  bit rsth   [MAXE];
  bit slowh  [MAXE];
  bit hreqh  [MAXE];
  bit rawh   [3][MAXE];
  bit pressh [3][MAXE];
  bit stab   [3];
  int hold   [3];
  int e;
  int cyc;
  int total;
  int bad;
  int exp_state;
  int exp_en;
  int exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, obs, expv);
    end
  endtask

  // Synchronised button value seen by the debouncer at edge k
  function automatic bit dsync(input int b, input int k);
    if (rsth[k-1] || rsth[k-2]) return 1'b0;
    return rawh[b][k-2];
  endfunction

  // A slow_in rising edge reaches the FSM three edges after it is sampled
  function automatic bit tick_at(input int m);
    if (rsth[m-1] || rsth[m-2] || rsth[m-3]) return 1'b0;
    return slowh[m-2] && !slowh[m-3];
  endfunction

  // Level change accepted when the last N synchronised samples all disagree
  function automatic bit accept(input int b, input int j);
    for (int k = j - N + 1; k <= j; k++) begin
      if (rsth[k]) return 1'b0;
      if (dsync(b, k) == stab[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit tk, rp, sp, hp, halt;
    if (rsth[e]) begin
      exp_state = 0;
      exp_en    = 0;
      exp_cnt   = 0;
      for (int b = 0; b < 3; b++) begin
        stab[b]      = 1'b0;
        pressh[b][e] = 1'b0;
      end
      return;
    end
    tk   = tick_at(e);
    rp   = pressh[0][e-1];
    sp   = pressh[1][e-1];
    hp   = pressh[2][e-1];
    halt = hp || hreqh[e];
    exp_en = 0;
    case (exp_state)
      0: if (!halt) begin
           if (rp)      exp_state = 1;
           else if (sp) exp_state = 2;
         end
      1: if (halt) exp_state = 0;
         else      exp_en = tk ? 1 : 0;
      default: if (halt) exp_state = 0;
               else if (tk) begin exp_state = 0; exp_en = 1; end
    endcase
    exp_cnt = (exp_cnt + exp_en) % (1 << CW);
    for (int b = 0; b < 3; b++) begin
      pressh[b][e] = 1'b0;
      if (accept(b, e)) begin
        stab[b]      = ~stab[b];
        pressh[b][e] = stab[b];
      end
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    e++;
    rsth[e]    = rst;
    slowh[e]   = slow_in;
    hreqh[e]   = halt_req;
    rawh[0][e] = btn_run;
    rawh[1][e] = btn_step;
    rawh[2][e] = btn_halt;
    model_edge();
    #1;
    chk("cpu_en", {31'd0, cpu_en}, exp_en);
    chk("state", {30'd0, state}, exp_state);
    chk("step_count", {28'd0, step_count}, exp_cnt);
  endtask

  task automatic drive(input bit r, input int prun, input int pstep, input int phalt, input int preq);
    int prob [3];
    bit raw  [3];
    prob[0] = prun;
    prob[1] = pstep;
    prob[2] = phalt;
    @(negedge clk);
    cyc++;
    slow_in = ((cyc / 10) % 2) == 1;
    for (int b = 0; b < 3; b++) begin
      if (hold[b] > 0) begin
        raw[b] = 1'b1;
        hold[b]--;
      end else begin
        raw[b] = 1'b0;
        if (prob[b] != 0 && $urandom_range(prob[b] - 1, 0) == 0)
          hold[b] = $urandom_range(9, 1);
      end
    end
    btn_run  = raw[0];
    btn_step = raw[1];
    btn_halt = raw[2];
    if (halt_req) halt_req = ($urandom_range(2, 0) != 0);
    else          halt_req = (preq != 0) && ($urandom_range(preq - 1, 0) == 0);
    rst = r;
    clock_edge();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    e     = 15;
    cyc   = 10;
    exp_state = 0;
    exp_en    = 0;
    exp_cnt   = 0;
    for (int i = 0; i <= 15; i++) rsth[i] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      stab[b] = 1'b0;
      hold[b] = 0;
    end

    // Reset while slow_in is already high, then idle: no tick until next rise
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) drive(1'b0, 0, 0, 0, 0);

    // Mixed random button activity, halt requests and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(799, 0) == 0) || (rst && $urandom_range(1, 0) == 1);
      drive(r, 45, 30, 160, 200);
    end

    // Long uninterrupted run from a clean reset so step_count wraps
    hold[0] = 0; hold[1] = 0; hold[2] = 0;
    halt_req = 1'b0;
    drive(1'b1, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0);
    hold[0] = 8;
    for (int i = 0; i < 420; i++) drive(1'b0, 0, 0, 0, 0);
    chk("wrap_count", {28'd0, step_count}, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
